// File: rtl/display_arbiter.sv
// Round-robin arbiter sharing one seven-segment word and LED bank among four sources.
// Each grant keeps the display for a minimum hold time, and outputs are registered toward the board.
module display_arbiter #(
    parameter int N_REQ       = 4,
    parameter int HOLD_CYCLES = 50_000_000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [32*N_REQ-1:0]    seg7_in,
    input  logic [10*N_REQ-1:0]    led_in,
    output logic [N_REQ-1:0]       gnt,
    output logic                   gnt_valid,
    output logic                   gnt_change,
    output logic [31:0]            seg7_num,
    output logic [9:0]             led,
    output logic [1:0]             state_dbg
);
    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(HOLD_CYCLES + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, OPEN = 2'd2} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [IW-1:0]    last;

    logic             found_other;
    logic [IW-1:0]    pick_other;
    logic             holder_req;
    logic             expired;
    logic             take_new;
    logic             go_idle;
    logic [IW-1:0]    new_idx;
    logic [N_REQ-1:0] nxt_gnt;
    logic [31:0]      nxt_seg;
    logic [9:0]       nxt_led;

    // Handshake: req[i] is a level request held for as long as source i wants the display;
    // gnt is one-hot ownership, and a holder releases by dropping req, with the effect seen one edge later.
    assign gnt_valid = |gnt;
    assign state_dbg = state;

    // First pending requester after the pointer, excluding the pointer itself.
    always_comb begin
        found_other = 1'b0;
        pick_other  = last;
        for (int k = N_REQ - 1; k >= 1; k--) begin
            if (req[last + IW'(k)]) begin
                found_other = 1'b1;
                pick_other  = last + IW'(k);
            end
        end
    end

    assign holder_req = req[last];
    assign expired    = (state == OPEN) || (state == HOLD && cnt == '0);

    always_comb begin
        take_new = 1'b0;
        go_idle  = 1'b0;
        new_idx  = pick_other;
        case (state)
            IDLE: begin
                // The pointer itself is the last slot searched from idle.
                if (found_other || req[last]) begin
                    take_new = 1'b1;
                    new_idx  = found_other ? pick_other : last;
                end
            end
            HOLD, OPEN: begin
                if (!holder_req) begin
                    if (found_other) take_new = 1'b1;
                    else             go_idle  = 1'b1;
                end else if (expired && found_other) begin
                    take_new = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        nxt_gnt = gnt;
        if (take_new)     nxt_gnt = N_REQ'(1) << new_idx;
        else if (go_idle) nxt_gnt = '0;
    end

    always_comb begin
        nxt_seg = '0;
        nxt_led = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (nxt_gnt[i]) begin
                nxt_seg = seg7_in[32*i +: 32];
                nxt_led = led_in[10*i +: 10];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            last       <= IW'(N_REQ - 1);
            gnt        <= '0;
            gnt_change <= 1'b0;
        end else begin
            gnt        <= nxt_gnt;
            gnt_change <= take_new;
            if (take_new) begin
                state <= HOLD;
                cnt   <= CW'(HOLD_CYCLES - 1);
                last  <= new_idx;
            end else if (go_idle) begin
                state <= IDLE;
                cnt   <= '0;
            end else if (state == HOLD) begin
                if (cnt == '0) state <= OPEN;
                else           cnt   <= cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg7_num <= '0;
            led      <= '0;
        end else begin
            seg7_num <= nxt_seg;
            led      <= nxt_led;
        end
    end
endmodule

// File: tb/tb_display_arbiter.sv
// Directed bench for display_arbiter with HOLD_CYCLES=4. Expected output words are queued
// when inputs are driven and checked one cycle later.
module tb_display_arbiter;
    localparam int W = 48;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [3:0]    req;
    logic [127:0]  seg7_in;
    logic [39:0]   led_in;
    logic [3:0]    gnt;
    logic          gnt_valid;
    logic          gnt_change;
    logic [31:0]   seg7_num;
    logic [9:0]    led;
    logic [1:0]    state_dbg;

    logic [31:0]   sd [4];
    logic [9:0]    ld [4];
    logic [W-1:0]  exp_q [$];
    logic [W-1:0]  obs_w;
    int            n_cmp = 0;
    int            n_mis = 0;

    display_arbiter #(.N_REQ(4), .HOLD_CYCLES(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .seg7_in    (seg7_in),
        .led_in     (led_in),
        .gnt        (gnt),
        .gnt_valid  (gnt_valid),
        .gnt_change (gnt_change),
        .seg7_num   (seg7_num),
        .led        (led),
        .state_dbg  (state_dbg)
    );

    always #5 clk = ~clk;

    assign seg7_in = {sd[3], sd[2], sd[1], sd[0]};
    assign led_in  = {ld[3], ld[2], ld[1], ld[0]};
    assign obs_w   = {gnt, gnt_valid, gnt_change, seg7_num, led};

    function automatic logic [W-1:0] ew(input logic [3:0] g, input logic ch);
        logic [31:0] s;
        logic [9:0]  l;
        s = '0;
        l = '0;
        for (int i = 0; i < 4; i++) begin
            if (g[i]) begin
                s = sd[i];
                l = ld[i];
            end
        end
        return {g, |g, ch, s, l};
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_now(input string tag);
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check(tag, obs_w, e);
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        @(negedge clk);
        check_now(tag);
    endtask

    task automatic check_state(input string tag, input logic [1:0] exp);
        n_cmp++;
        assert (state_dbg === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0d expected=%0d", tag, state_dbg, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 4'b0000;
        exp_q.push_back(ew(4'b0000, 1'b0));
        tick("reset_cycle");
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            sd[i] = 32'h1000_0001 * (i + 1);
            ld[i] = 10'(10'h021 * (i + 1));
        end
        repeat (2) @(negedge clk);
        exp_q.push_back(ew(4'b0000, 1'b0));
        check_now("reset_outputs");
        check_state("reset_state", 2'd0);
        rst_n = 1'b1;

        // Single requester holds indefinitely; live data tracking mid-grant.
        sd[2] = 32'h0102_0304;
        ld[2] = 10'h155;
        req   = 4'b0100;
        exp_q.push_back(ew(4'b0100, 1'b1));
        tick("single_first");
        for (int i = 1; i < 20; i++) begin
            if (i == 10) begin
                sd[2] = 32'hCAFE_F00D;
                ld[2] = 10'h2AA;
            end
            exp_q.push_back(ew(4'b0100, 1'b0));
            tick("single_hold");
        end
        check_state("single_open_state", 2'd2);

        // Holder in OPEN drops: idle, outputs zero, no change pulse.
        req = 4'b0000;
        exp_q.push_back(ew(4'b0000, 1'b0));
        tick("drop_idle");
        exp_q.push_back(ew(4'b0000, 1'b0));
        tick("idle_stays");

        // Asynchronous reset in the middle of a grant.
        req = 4'b0010;
        exp_q.push_back(ew(4'b0010, 1'b1));
        tick("pre_reset_grant");
        #2 rst_n = 1'b0;
        #1;
        exp_q.push_back(ew(4'b0000, 1'b0));
        check_now("async_reset");
        check_state("async_reset_state", 2'd0);
        req = 4'b0000;
        exp_q.push_back(ew(4'b0000, 1'b0));
        tick("reset_held");
        rst_n = 1'b1;
        req   = 4'b0010;
        exp_q.push_back(ew(4'b0010, 1'b1));
        tick("post_reset_grant");

        // Simultaneous start: 0 first for exactly 4 cycles, then 1, then back to 0.
        do_reset();
        req = 4'b0011;
        for (int c = 1; c <= 4; c++) begin
            exp_q.push_back(ew(4'b0001, c == 1));
            tick("simul_r0");
        end
        for (int c = 5; c <= 8; c++) begin
            exp_q.push_back(ew(4'b0010, c == 5));
            tick("simul_r1");
        end
        exp_q.push_back(ew(4'b0001, 1'b1));
        tick("simul_back_r0");

        // Early release before hold expiry.
        do_reset();
        req = 4'b0011;
        exp_q.push_back(ew(4'b0001, 1'b1));
        tick("early_c1");
        exp_q.push_back(ew(4'b0001, 1'b0));
        tick("early_c2");
        req = 4'b0010;
        exp_q.push_back(ew(4'b0010, 1'b1));
        tick("early_handover");
        exp_q.push_back(ew(4'b0010, 1'b0));
        tick("early_after");

        // Holder drop and competitor arrival in the same cycle.
        do_reset();
        req = 4'b0001;
        exp_q.push_back(ew(4'b0001, 1'b1));
        tick("swap_first");
        req = 4'b0100;
        exp_q.push_back(ew(4'b0100, 1'b1));
        tick("drop_arrive");

        // Full contention: strict rotation, 4 cycles per grant.
        do_reset();
        req = 4'b1111;
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 4; c++) begin
                exp_q.push_back(ew(4'(1 << (r % 4)), c == 0));
                tick("rotate");
            end
        end

        req = 4'b0000;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
